fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, single-outstanding imem request, IR latch and sticky fault.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap fetches from a PC with pc[1:0] != 0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_write,
  input  logic        pc_sel,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_busy,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state_r;
  logic [15:0] wait_cnt_r;
  logic        pend_valid_r;
  logic [31:0] pend_target_r;

  logic [31:0] write_target_s;
  logic [31:0] idle_pc_s;
  logic [31:0] fetch_addr_s;
  logic [15:0] wait_next_s;
  logic        misaligned_s;

  // PC selection for an IDLE edge: a fresh pc_write is newer than any pending entry and wins.
  always_comb begin
    write_target_s = pc_sel ? branch_target : (pc + 32'd4);
    if (pc_write) begin
      idle_pc_s = write_target_s;
    end else if (pend_valid_r) begin
      idle_pc_s = pend_target_r;
    end else begin
      idle_pc_s = pc;
    end
    wait_next_s = wait_cnt_r + 16'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned_s = (idle_pc_s[1:0] != 2'b00);
    fetch_addr_s = idle_pc_s;
`else
    misaligned_s = 1'b0;
    fetch_addr_s = {idle_pc_s[31:2], 2'b00};
`endif
  end

  // Fetch FSM with all outputs registered; reset is asynchronous so imem_req drops immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      wait_cnt_r    <= 16'd0;
      pend_valid_r  <= 1'b0;
      pend_target_r <= 32'h0000_0000;
      pc            <= RESET_PC;
      pc_plus4      <= RESET_PC + 32'd4;
      imem_req      <= 1'b0;
      imem_addr     <= RESET_PC;
      instruction   <= 32'h0000_0000;
      instr_valid   <= 1'b0;
      fetch_busy    <= 1'b0;
      fault         <= 1'b0;
      fault_cause   <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          pc           <= idle_pc_s;
          pc_plus4     <= idle_pc_s + 32'd4;
          pend_valid_r <= 1'b0;
          instr_valid  <= 1'b0;
          if (fetch_start && misaligned_s) begin
            state_r     <= ST_FAULT;
            fault       <= 1'b1;
            fault_cause <= 2'b11;
          end else if (fetch_start) begin
            state_r    <= ST_REQ;
            imem_req   <= 1'b1;
            imem_addr  <= fetch_addr_s;
            wait_cnt_r <= 16'd0;
            fetch_busy <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          // PC is frozen while a fetch is in flight; updates wait in the pending entry.
          if (pc_write) begin
            pend_valid_r  <= 1'b1;
            pend_target_r <= write_target_s;
          end
          if (imem_ack && imem_err) begin
            state_r     <= ST_FAULT;
            imem_req    <= 1'b0;
            fetch_busy  <= 1'b0;
            fault       <= 1'b1;
            fault_cause <= 2'b01;
          end else if (imem_ack) begin
            state_r     <= ST_VALID;
            imem_req    <= 1'b0;
            instruction <= imem_rdata;
            instr_valid <= 1'b1;
          end else if (wait_next_s == TIMEOUT_LIMIT) begin
            state_r     <= ST_FAULT;
            wait_cnt_r  <= wait_next_s;
            imem_req    <= 1'b0;
            fetch_busy  <= 1'b0;
            fault       <= 1'b1;
            fault_cause <= 2'b10;
          end else begin
            wait_cnt_r <= wait_next_s;
          end
        end
        ST_VALID: begin
          if (pc_write) begin
            pend_valid_r  <= 1'b1;
            pend_target_r <= write_target_s;
          end
          state_r     <= ST_IDLE;
          instr_valid <= 1'b0;
          fetch_busy  <= 1'b0;
        end
        ST_FAULT: begin
          state_r <= ST_FAULT;
        end
        default: begin
          state_r     <= ST_FAULT;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          fetch_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
